// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg -- shared definitions for the EX-stage multiply/divide unit.
//
// Contents:
//   INST_*       : RV32M instruction field codes used by the decoder
//   MDU_*        : funct3 operation select codes (MUL..REMU)
//   mdu_state_e  : IDLE/CALC/DONE state encoding of the iterative unit
//   op_signed_rs1/op_signed_rs2 : operand signedness of each funct3 code
package ex_mdu_pkg;

   // Instruction fields that select the M extension in the decoder.
   localparam logic [6:0] INST_OP_REG        = 7'b0110011;
   localparam logic [6:0] INST_FUNCT7_MULDIV = 7'b0000001;

   // funct3 operation codes.
   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   // rs1 is a two's complement value for MULH, MULHSU, DIV and REM.
   function automatic logic op_signed_rs1(input logic [2:0] funct3);
      return (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
             (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
   endfunction

   // rs2 is a two's complement value for MULH, DIV and REM.
   function automatic logic op_signed_rs2(input logic [2:0] funct3);
      return (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
   endfunction

endpackage

// File: rtl/ex_mdu_step.sv
// mdu_step -- one iteration of the unsigned magnitude datapath.
//
// Multiply (div_i=0): right-shifting shift-add. {acc,lo} holds the partial
//   product and the remaining multiplier bits; after XLEN steps {acc,lo} is
//   the 2*XLEN-bit product of the multiplier (initial lo) and opnd_i.
// Divide (div_i=1): restoring division. {acc,lo} shifts left one bit, the
//   divisor is subtracted from the partial remainder when it fits and the
//   quotient bit enters lo; after XLEN steps lo=quotient, acc=remainder.
//
// Ports:
//   div_i   : select divide step (1) or multiply step (0)
//   acc_i   : upper half (partial product / partial remainder)
//   lo_i    : lower half (multiplier bits / dividend bits + quotient)
//   opnd_i  : multiplicand or divisor magnitude
//   acc_o, lo_o : state after this step
module mdu_step #(
   parameter int XLEN = 32
) (
   input  logic            div_i,
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   diff;
   logic [XLEN-1:0] addend;

   always_comb begin
      addend = lo_i[0] ? opnd_i : '0;
      sum    = {1'b0, acc_i} + {1'b0, addend};
      rem_sh = {acc_i, lo_i[XLEN-1]};
      // The partial remainder is always below the divisor, so a borrow out
      // of the (XLEN+1)-bit subtraction means "divisor does not fit".
      diff   = rem_sh - {1'b0, opnd_i};

      if (div_i) begin
         acc_o = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
         lo_o  = {lo_i[XLEN-2:0], ~diff[XLEN]};
      end else begin
         acc_o = sum[XLEN:1];
         lo_o  = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu -- iterative RV M-extension multiply/divide unit for the EX stage.
//
// Operands are converted to magnitudes on start, processed one bit per cycle
// by mdu_step for XLEN cycles, and the sign is restored when the result is
// registered. Divide by zero and signed overflow bypass the iteration and
// produce their architectural result one cycle after start.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start_i       : begin an operation (accepted only in IDLE, without flush)
//   funct3_i      : operation select (MUL..REMU)
//   rs1_data_i    : multiplicand / dividend
//   rs2_data_i    : multiplier / divisor
//   wreg_addr_i   : destination register of the request
//   flush_i       : abort any in-flight operation
//   busy_o        : high while in CALC or DONE
//   wreg_en_o     : one-cycle result strobe (DONE)
//   wreg_addr_o   : destination register of the result
//   wreg_data_o   : result, held until the next result
module ex_mdu
   import ex_mdu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [2:0]            funct3_i,
   input  logic [XLEN-1:0]       rs1_data_i,
   input  logic [XLEN-1:0]       rs2_data_i,
   input  logic [REG_ADDR_W-1:0] wreg_addr_i,
   input  logic                  flush_i,
   output logic                  busy_o,
   output logic                  wreg_en_o,
   output logic [REG_ADDR_W-1:0] wreg_addr_o,
   output logic [XLEN-1:0]       wreg_data_o
);

   localparam int                CNT_W     = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]   XLEN_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e            state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [XLEN-1:0]       acc_q, acc_d;
   logic [XLEN-1:0]       lo_q, lo_d;
   logic [XLEN-1:0]       opnd_q, opnd_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  neg_q, neg_d;         // negate product / quotient
   logic                  neg_rem_q, neg_rem_d; // negate remainder
   logic [REG_ADDR_W-1:0] addr_q, addr_d;       // address of op in flight
   logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;

   // Request decode
   logic            rs1_neg, rs2_neg;
   logic [XLEN-1:0] rs1_mag, rs2_mag;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] special_val;

   // Iteration and result
   logic [XLEN-1:0]   acc_step, lo_step;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, result;

   mdu_step #(.XLEN(XLEN)) u_step (
      .div_i  (op_q[2]),
      .acc_i  (acc_q),
      .lo_i   (lo_q),
      .opnd_i (opnd_q),
      .acc_o  (acc_step),
      .lo_o   (lo_step)
   );

   always_comb begin
      rs1_neg = op_signed_rs1(funct3_i) && rs1_data_i[XLEN-1];
      rs2_neg = op_signed_rs2(funct3_i) && rs2_data_i[XLEN-1];
      rs1_mag = rs1_neg ? -rs1_data_i : rs1_data_i;
      rs2_mag = rs2_neg ? -rs2_data_i : rs2_data_i;

      div_zero = funct3_i[2] && (rs2_data_i == '0);
      div_ovf  = ((funct3_i == MDU_DIV) || (funct3_i == MDU_REM)) &&
                 (rs1_data_i == XLEN_MIN) && (rs2_data_i == '1);
      special  = div_zero || div_ovf;

      // funct3[1] distinguishes REM/REMU from DIV/DIVU.
      if (div_zero)
         special_val = funct3_i[1] ? rs1_data_i : '1;
      else
         special_val = funct3_i[1] ? '0 : rs1_data_i;
   end

   // Sign restoration uses the final step's outputs so the result is ready
   // at the same edge that leaves CALC.
   always_comb begin
      prod     = {acc_step, lo_step};
      prod_fix = neg_q ? -prod : prod;
      quot_fix = neg_q ? -lo_step : lo_step;
      rem_fix  = neg_rem_q ? -acc_step : acc_step;

      unique case (op_q)
         MDU_MUL:                       result = prod_fix[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: result = prod_fix[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:             result = quot_fix;
         default:                       result = rem_fix;
      endcase
   end

   always_comb begin
      // NOTE: every next-state variable gets its hold value first, so no
      // path through the case below can leave one unassigned and infer a latch.
      state_d   = state_q;
      op_d      = op_q;
      acc_d     = acc_q;
      lo_d      = lo_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      addr_d    = addr_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;

      if (flush_i) begin
         // Abort wins over everything, including a simultaneous start and
         // the final iteration; the result registers keep their old value.
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  op_d      = funct3_i;
                  addr_d    = wreg_addr_i;
                  cnt_d     = '0;
                  acc_d     = '0;
                  lo_d      = rs1_mag;
                  opnd_d    = rs2_mag;
                  neg_d     = rs1_neg ^ rs2_neg;
                  neg_rem_d = rs1_neg;
                  if (special) begin
                     waddr_d = wreg_addr_i;
                     wdata_d = special_val;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_CALC;
                  end
               end
            end

            ST_CALC: begin
               acc_d = acc_step;
               lo_d  = lo_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  waddr_d = addr_q;
                  wdata_d = result;
                  state_d = ST_DONE;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the datapath registers are reset too: after reset the
         // result outputs must read zero and no stale operand can leak out.
         state_q   <= ST_IDLE;
         op_q      <= '0;
         acc_q     <= '0;
         lo_q      <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         addr_q    <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         lo_q      <= lo_d;
         opnd_q    <= opnd_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         addr_q    <= addr_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign wreg_en_o   = (state_q == ST_DONE);
   assign wreg_addr_o = waddr_q;
   assign wreg_data_o = wdata_q;

endmodule
